// File: rtl/cut_tester_pkg.sv
// Shared constants for the exhaustive CUT tester: FSM state encoding, MISR seed and
// the default golden response / feedback polynomial.
package cut_tester_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StApply   = 2'd1;
  localparam state_t StCapture = 2'd2;
  localparam state_t StDone    = 2'd3;

  localparam logic [15:0] MisrSeed        = 16'hFFFF;
  localparam logic [15:0] DefaultPoly     = 16'h1021;
  localparam logic [31:0] DefaultExpected = 32'hEFFE_FEFE;

endpackage

// File: rtl/sig_misr.sv
// 16-bit single-input signature register: seeded at run start, shifted once per captured
// response bit.
module sig_misr #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic        shift_en,
  input  logic        din,
  output logic [15:0] sig
);

  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (seed_load) begin
      sig_d = SEED;
    end else if (shift_en) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ {15'b0, din};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= 16'h0000;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/cut_tester.sv
// Exhaustive pattern tester for a small combinational CUT; compares each response with a
// golden truth table. Define CUT_TESTER_MISR_EN to also compact responses into a MISR.
module cut_tester
  import cut_tester_pkg::*;
#(
  parameter int unsigned           N_IN     = 5,
  parameter int unsigned           SETTLE   = 1,
  parameter logic [2**N_IN-1:0]    EXPECTED = DefaultExpected,
  parameter logic [15:0]           POLY     = DefaultPoly
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] pat_out,
  input  logic            resp_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            first_fail_vld,
  output logic [15:0]     signature
);

  localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);

  state_t              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [N_IN:0]       cnt_q, cnt_d;
  logic [N_IN-1:0]     ffi_q, ffi_d;
  logic                ffv_q, ffv_d;
  logic                pass_q, pass_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    ffi_d    = ffi_q;
    ffv_d    = ffv_q;
    pass_d   = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StApply;
          idx_d    = '0;
          settle_d = '0;
          cnt_d    = '0;
          ffi_d    = '0;
          ffv_d    = 1'b0;
          pass_d   = 1'b0;
        end
      end
      StApply: begin
        if (settle_q == SettleLast) begin
          state_d  = StCapture;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StCapture: begin
        if (resp_in != EXPECTED[idx_q]) begin
          cnt_d = cnt_q + 1'b1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q;
          end
        end
        // Last pattern: idx stays at its maximum rather than wrapping.
        if (idx_q == '1) begin
          state_d = StDone;
          pass_d  = (cnt_d == '0);
        end else begin
          state_d = StApply;
          idx_d   = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      ffi_q    <= '0;
      ffv_q    <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      ffi_q    <= ffi_d;
      ffv_q    <= ffv_d;
      pass_q   <= pass_d;
    end
  end

  assign busy           = (state_q == StApply) || (state_q == StCapture);
  assign done           = (state_q == StDone);
  assign pat_out        = busy ? idx_q : '0;
  assign pass           = pass_q;
  assign mismatch_cnt   = cnt_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vld = ffv_q;

`ifdef CUT_TESTER_MISR_EN
  logic seed_load, shift_en;

  assign seed_load = (state_q == StIdle) && start;
  assign shift_en  = (state_q == StCapture);

  sig_misr #(
    .POLY (POLY),
    .SEED (MisrSeed)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .shift_en  (shift_en),
    .din       (resp_in),
    .sig       (signature)
  );
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_cut_tester.sv
// Directed + randomized bench for cut_tester; the CUT is modelled as a 32-entry truth table.
module tb_cut_tester;

  localparam int unsigned N_IN   = 5;
  localparam int unsigned SETTLE = 1;
  localparam logic [31:0] EXP    = 32'hEFFE_FEFE;
  localparam logic [15:0] POLY   = 16'h1021;
  localparam int          RUN_CYCLES = (2**N_IN) * (SETTLE + 1);
  localparam int          DONE_CYC   = RUN_CYCLES + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [N_IN-1:0] pat_out;
  logic            resp_in;
  logic            busy, done, pass, first_fail_vld;
  logic [N_IN:0]   mismatch_cnt;
  logic [N_IN-1:0] first_fail_idx;
  logic [15:0]     signature;
  logic [31:0]     cut_tbl = EXP;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // The CUT is combinational: response bit is the truth-table entry for the applied pattern.
  assign resp_in = cut_tbl[pat_out];

  cut_tester #(
    .N_IN     (N_IN),
    .SETTLE   (SETTLE),
    .EXPECTED (EXP),
    .POLY     (POLY)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .pat_out        (pat_out),
    .resp_in        (resp_in),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_cnt   (mismatch_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_vld (first_fail_vld),
    .signature      (signature)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int popcount(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int lowest_set(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] misr_ref(input logic [31:0] tbl);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ {15'b0, tbl[i]};
    end
    return s;
  endfunction

  function automatic logic [15:0] sig_ref(input logic [31:0] tbl);
`ifdef CUT_TESTER_MISR_EN
    return misr_ref(tbl);
`else
    return (tbl == tbl) ? 16'h0000 : misr_ref(tbl);
`endif
  endfunction

  task automatic check_results(input string tag, input logic [31:0] tbl);
    logic [31:0] diff;
    int          mm;
    diff = tbl ^ EXP;
    mm   = popcount(diff);
    check({tag, "_pass"}, 32'(pass), 32'(mm == 0));
    check({tag, "_cnt"}, 32'(mismatch_cnt), 32'(mm));
    check({tag, "_ffv"}, 32'(first_fail_vld), 32'(mm != 0));
    if (mm != 0) check({tag, "_ffi"}, 32'(first_fail_idx), 32'(lowest_set(diff)));
    check({tag, "_sig"}, 32'(signature), 32'(sig_ref(tbl)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pat"}, 32'(pat_out), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_cnt"}, 32'(mismatch_cnt), 0);
    check({tag, "_ffi"}, 32'(first_fail_idx), 0);
    check({tag, "_ffv"}, 32'(first_fail_vld), 0);
    check({tag, "_sig"}, 32'(signature), 0);
  endtask

  // Cycle c is the c-th clock period after the edge that sampled start; outputs are sampled
  // 1 time unit into each period. extra_start > 0 pulses start once mid-run.
  task automatic run_check(input string tag, input logic [31:0] tbl, input int extra_start);
    int          done_cnt = 0;
    int          done_at = 0;
    int          bad_pat = 0;
    logic        pass_at_done = 1'b0;
    logic [N_IN-1:0] exp_pat;
    cut_tbl = tbl;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= DONE_CYC + 5; c++) begin
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = c;
          pass_at_done = pass;
        end
      end
      if (c <= RUN_CYCLES) begin
        exp_pat = N_IN'((c - 1) / (SETTLE + 1));
        if (pat_out !== exp_pat || busy !== 1'b1) bad_pat++;
      end else if (pat_out !== '0 || busy !== 1'b0) begin
        bad_pat++;
      end
      start = (extra_start > 0 && c == extra_start);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_at), 32'(DONE_CYC));
    check({tag, "_done_pulses"}, 32'(done_cnt), 1);
    check({tag, "_pat_busy"}, 32'(bad_pat), 0);
    check({tag, "_pass_at_done"}, 32'(pass_at_done), 32'(popcount(tbl ^ EXP) == 0));
    check_results(tag, tbl);
  endtask

  initial begin
    logic [31:0] c_stuck;
    logic [31:0] rtbl;
    logic [15:0] sig_good;
    int          dc;
    int          done_q[$];

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Fault-free, stuck-at-1, stuck-at-0 on f.
    run_check("fault_free", EXP, 0);
    sig_good = signature;
    check("ff_cnt_zero", 32'(mismatch_cnt), 0);
    run_check("f_sa1", 32'hFFFF_FFFF, 0);
    check("sa1_cnt4", 32'(mismatch_cnt), 4);
    check("sa1_ffi0", 32'(first_fail_idx), 0);
    run_check("f_sa0", 32'h0000_0000, 0);
    check("sa0_cnt28", 32'(mismatch_cnt), 28);
    check("sa0_ffi1", 32'(first_fail_idx), 1);

    // Input c (pattern bit 2) stuck-at-0.
    for (int i = 0; i < 32; i++) c_stuck[i] = EXP[i & 27];
    run_check("c_sa0", c_stuck, 0);
`ifdef CUT_TESTER_MISR_EN
    check("c_sa0_sig_differs", 32'(signature != sig_good), 1);
`endif

    // Randomized faulty truth tables with random idle gaps.
    for (int r = 0; r < 4; r++) begin
      rtbl = $urandom();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1 run_check($sformatf("rand%0d", r), rtbl, 0);
    end

    // Start pulsed during APPLY is ignored.
    run_check("start_in_apply", c_stuck, 11);

    // Reset mid-run aborts without a done pulse.
    cut_tbl = EXP;
    dc = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (done) dc++;
      if (c == 20) rst_n = 1'b0;
      if (c == 21) begin
        check_all_zero("midrun_reset");
        rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("midrun_no_done", 32'(dc), 0);
    run_check("post_reset", EXP, 0);

    // Start held high across DONE starts a second run right after the IDLE cycle.
    cut_tbl = 32'h0000_0000;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 2 * DONE_CYC + 10; c++) begin
      if (done) done_q.push_back(c);
      if (c == 2 * DONE_CYC + 1) start = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("held_start_pulses", 32'(done_q.size()), 2);
    if (done_q.size() == 2) begin
      check("held_start_first", 32'(done_q[0]), 32'(DONE_CYC));
      check("held_start_second", 32'(done_q[1]), 32'(2 * DONE_CYC + 1));
    end
    check_results("held_start", 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
